// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding, frame geometry and the
// default bit period used by both uart_tx_arbiter and uart_rx.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SEND
   } uart_arb_state_t;

   // start + 8 data + stop
   localparam int UART_FRAME_BITS   = 10;
   localparam int UART_CLKS_PER_BIT = 10;

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer: a one-cycle start pulse loads a byte, and done pulses during
// the final clock of the stop bit so a follow-on byte can start without a gap.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx_out,
   output logic       done
);

   localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int CNT_W = $clog2(UART_FRAME_BITS);

   logic [DIV_W-1:0]           div_reg;
   logic [CNT_W-1:0]           bit_reg;
   logic [UART_FRAME_BITS-2:0] frame_reg;
   logic                       active_reg;
   logic                       tx_reg;
   logic                       bit_end;

   assign bit_end = active_reg && (div_reg == DIV_W'(CLKS_PER_BIT - 1));
   assign done    = bit_end && (bit_reg == CNT_W'(UART_FRAME_BITS - 1));
   assign tx_out  = tx_reg;

   // frame_reg holds the bits still to be sent (data then stop), LSB next.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_reg <= 1'b0;
         tx_reg     <= 1'b1;
         div_reg    <= '0;
         bit_reg    <= '0;
         frame_reg  <= '1;
      end else if (start) begin
         active_reg <= 1'b1;
         tx_reg     <= 1'b0;
         div_reg    <= '0;
         bit_reg    <= '0;
         frame_reg  <= {1'b1, data};
      end else if (active_reg) begin
         if (bit_end) begin
            div_reg <= '0;
            if (done) begin
               active_reg <= 1'b0;
               tx_reg     <= 1'b1;
            end else begin
               bit_reg   <= bit_reg + CNT_W'(1);
               tx_reg    <= frame_reg[0];
               frame_reg <= {1'b1, frame_reg[UART_FRAME_BITS-2:1]};
            end
         end else begin
            div_reg <= div_reg + DIV_W'(1);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one 8N1 transmit line between
// NUM_REQ producers. Optional owner-stall eviction: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int TIMEOUT_CLKS = 1000
) (
   input  logic                                            clk,
   input  logic                                            rst_n,
   input  logic [NUM_REQ-1:0]                              req_valid,
   input  logic [NUM_REQ*8-1:0]                            req_data,
   input  logic [NUM_REQ-1:0]                              req_last,
   output logic [NUM_REQ-1:0]                              req_ready,
   output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
   output logic                                            busy,
   output logic                                            err_timeout,
   output logic                                            tx_out
);

   localparam int GRANT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   uart_arb_state_t    state_reg, state_next;
   logic [GRANT_W-1:0] grant_reg, grant_next;
   logic [GRANT_W-1:0] last_grant_reg, last_grant_next;
   logic [GRANT_W-1:0] rr_pick;
   logic               last_reg, last_next;
   logic               owner_valid;
   logic [7:0]         owner_data;
   logic               ser_start;
   logic               ser_done;
   logic               to_hit;

   assign owner_valid = req_valid[grant_reg];
   assign owner_data  = req_data[grant_reg*8 +: 8];
   assign ser_start   = (state_reg == LOAD) && owner_valid;
   assign busy        = (state_reg != IDLE);
   assign grant_id    = grant_reg;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
         assign req_ready[gi] = (state_reg == LOAD) && (grant_reg == GRANT_W'(gi));
      end
   endgenerate

   // Scan downwards so the requester closest after last_grant wins.
   always_comb begin
      rr_pick = last_grant_reg;
      for (int i = NUM_REQ; i >= 1; i--) begin
         if (req_valid[(int'(last_grant_reg) + i) % NUM_REQ]) begin
            rr_pick = GRANT_W'((int'(last_grant_reg) + i) % NUM_REQ);
         end
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);

   logic [TO_W-1:0] to_cnt_reg;
   logic            err_reg;

   assign to_hit      = (state_reg == LOAD) && !owner_valid &&
                        (to_cnt_reg == TO_W'(TIMEOUT_CLKS - 1));
   assign err_timeout = err_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt_reg <= '0;
         err_reg    <= 1'b0;
      end else begin
         err_reg <= to_hit;
         if ((state_reg == LOAD) && !owner_valid && !to_hit) begin
            to_cnt_reg <= to_cnt_reg + TO_W'(1);
         end else begin
            to_cnt_reg <= '0;
         end
      end
   end
`else
   assign to_hit      = 1'b0;
   assign err_timeout = 1'b0;
`endif

   always_comb begin
      state_next      = state_reg;
      grant_next      = grant_reg;
      last_grant_next = last_grant_reg;
      last_next       = last_reg;
      case (state_reg)
         IDLE: begin
            if (|req_valid) begin
               state_next      = LOAD;
               grant_next      = rr_pick;
               last_grant_next = rr_pick;
            end
         end
         LOAD: begin
            if (owner_valid) begin
               state_next = SEND;
               last_next  = req_last[grant_reg];
            end else if (to_hit) begin
               state_next = IDLE;
            end
         end
         SEND: begin
            if (ser_done) begin
               state_next = last_reg ? IDLE : LOAD;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         grant_reg      <= '0;
         last_grant_reg <= GRANT_W'(NUM_REQ - 1);
         last_reg       <= 1'b0;
      end else begin
         state_reg      <= state_next;
         grant_reg      <= grant_next;
         last_grant_reg <= last_grant_next;
         last_reg       <= last_next;
      end
   end

   uart_tx_serializer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_serializer (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (ser_start),
      .data   (owner_data),
      .tx_out (tx_out),
      .done   (ser_done)
   );

endmodule
